permute_engine: RTL and testbench
=================================

Name: permute_engine

Overview:
Parametrised, multi-round successor to the single-shot permute unit. It takes a 25-lane Keccak-style state of LANE_W bits per lane and applies a runtime-selected step (rho, pi, or rho followed by pi) for a programmable number of rounds, one round per clock. It sits between the state register file and the sponge controller, with a start/busy/done handshake.

Parameters:
LANE_W, 64, bits per lane; legal values are 8, 16, 32, 64. State width is S = 25*LANE_W.
NUM_ROUNDS, 24, maximum round count; the round counter width is clog2(NUM_ROUNDS+1).

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
mode  in  2  step select: 00 = rho, 01 = pi, 10 = rho then pi, 11 = reserved, treated as 10.
rounds  in  clog2(NUM_ROUNDS+1)  round count; latched at start.
data_in  in  S  input state; latched at start.
busy  out  1  high while rounds are executing.
done  out  1  one-cycle pulse when the result is valid.
data_out  out  S  result; held stable from done until the next accepted start.

Behaviour:
- Bit mapping: lane (x,y) with x,y in 0..4 has index L = x+5y; bit z of that lane is at S-bit position L*LANE_W+z.
- rho: lane (x,y) rotates left by R[x][y] mod LANE_W.
  - R rows y=0..4, each listing x=0..4:
    - y=0: 0, 1, 62, 28, 27
    - y=1: 36, 44, 6, 55, 20
    - y=2: 3, 10, 43, 25, 39
    - y=3: 41, 45, 15, 21, 8
    - y=4: 18, 2, 61, 56, 14
- pi: output lane (y, (2x+3y) mod 5) = input lane (x,y). All indexing is mod 5; there are no width changes.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches data_in into the state register, latches mode and rounds, and sets cnt=rounds.
    - rounds > NUM_ROUNDS is clamped to NUM_ROUNDS.
    - Next state is RUN if cnt != 0, otherwise DONE.
  - RUN: busy=1. Each cycle, state <= round(state, mode) and cnt <= cnt-1. When cnt==1, the last round is written and the next state is DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge t; done is high in cycle t+rounds+1; rounds=0 gives done at t+1 with data_out equal to data_in (bypass).
- data_out is driven directly from the state register.
  - Intermediate round values are visible on data_out while busy=1.
  - Consumers sample data_out only on done or while idle.
- start while in RUN or DONE is ignored; it is neither queued nor restarted. start held high in IDLE immediately after DONE begins a new operation.
- Reset values: state IDLE, busy 0, done 0, data_out 0, cnt 0, latched mode 00.
- rst mid-RUN aborts on that edge and applies the reset values. No done is produced for the aborted job.
- rst and start high in the same cycle: rst wins.
- mode changes after start have no effect on the running job.

Decomposition:
- Shared package/include (extends the existing ISA defines):
  - NUM_LANES = 25
  - mode encodings MODE_RHO, MODE_PI, MODE_RHOPI
  - the 25-entry rho offset table as constants
  - state encodings for IDLE/RUN/DONE
- Sub-module permute_round: purely combinational, parameter LANE_W, ports state_in[S], mode[2], state_out[S]. It implements rho and pi via generate loops.
- The top level holds the FSM, the round counter and the state register. Controller and datapath split is optional; a single FSM block is acceptable.

Test Plan:
- LANE_W=64, data_in = bit 64 only (lane 1, z=0), mode=00, rounds=1 -> done at t+2; data_out has bit 65 only.
- Same input, mode=01, rounds=1 -> data_out has bit 640 only (lane 10, z=0).
- Same input, mode=10, rounds=1 -> data_out has bit 641 only (rotate by 1, then moved to lane 10). The same stimulus with rounds=0 -> done at t+1, data_out = bit 64.
- Random 1600-bit state, mode=01, rounds=24 -> matches the software model; busy is high for exactly 24 cycles; done is a single-cycle pulse.
- start pulsed again at cycle t+5 of a 24-round job -> ignored; exactly one done at t+25; a new job is accepted in the following IDLE cycle.
- rst asserted at t+10 of a 24-round job -> next cycle busy=0, done=0, data_out=0; no done appears afterward; a fresh start with rounds=2 completes normally. Repeat with LANE_W=8 and rounds=30 (clamped to 24).

Source files
------------

// File: rtl/permute_engine_pkg.sv
// Shared constants for the permute engine: lane count, step-select encodings,
// rho rotation offsets and controller state encodings.
package permute_engine_pkg;

    localparam int NUM_LANES = 25;

    // Step select. The fourth code (2'b11) is reserved and behaves as MODE_RHOPI.
    localparam logic [1:0] MODE_RHO   = 2'b00;
    localparam logic [1:0] MODE_PI    = 2'b01;
    localparam logic [1:0] MODE_RHOPI = 2'b10;

    // Rho rotate-left offsets indexed by lane L = x + 5*y. The offsets are given
    // for 64-bit lanes and are reduced mod LANE_W where they are used.
    localparam int RHO_OFS [NUM_LANES] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fsm_e;

    // Destination lane of pi for source lane (x,y): (y, (2x+3y) mod 5).
    function automatic int pi_dst(input int lane);
        int x;
        int y;
        x = lane % 5;
        y = lane / 5;
        return y + 5 * ((2 * x + 3 * y) % 5);
    endfunction

endpackage

// File: rtl/permute_engine_if.sv
// Start/busy/done handshake and state buses between the sponge controller
// (master) and the permute engine (slave).
interface permute_engine_if
    import permute_engine_pkg::*;
#(
    parameter int LANE_W     = 64,
    parameter int NUM_ROUNDS = 24
);
    localparam int S     = NUM_LANES * LANE_W;
    localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] rounds;
    logic [S-1:0]     data_in;
    logic             busy;
    logic             done;
    logic [S-1:0]     data_out;

    modport master (
        output start, mode, rounds, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, mode, rounds, data_in,
        output busy, done, data_out
    );

endinterface

// File: rtl/permute_round.sv
// One combinational round: rho, pi, or rho followed by pi over a 25-lane state.
module permute_round
    import permute_engine_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [NUM_LANES*LANE_W-1:0] state_in,
    input  logic [1:0]                  mode,
    output logic [NUM_LANES*LANE_W-1:0] state_out
);
    localparam int S = NUM_LANES * LANE_W;

    logic [S-1:0] rho_s;
    logic [S-1:0] pi_in;
    logic [S-1:0] pi_s;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam int ROT = RHO_OFS[l] % LANE_W;
        localparam int DST = pi_dst(l);

        logic [LANE_W-1:0] lane_in;

        assign lane_in = state_in[l*LANE_W +: LANE_W];

        // A zero offset shifts right by the full lane width, which yields zero,
        // so the OR reduces to the unrotated lane without a special case.
        assign rho_s[l*LANE_W +: LANE_W] = (lane_in << ROT) | (lane_in >> (LANE_W - ROT));

        assign pi_s[DST*LANE_W +: LANE_W] = pi_in[l*LANE_W +: LANE_W];
    end

    // pi works on the raw state for pi-only, otherwise on the rho result
    assign pi_in     = (mode == MODE_PI) ? state_in : rho_s;
    assign state_out = (mode == MODE_RHO) ? rho_s : pi_s;

endmodule

// File: rtl/permute_engine.sv
// Multi-round permute engine: latches a state at start, applies one round per
// clock for the requested round count, then pulses done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; data_out holds the last result
// RUN     | one round per clock, cnt counts remaining rounds
// DONE    | single-cycle done pulse, result valid on data_out
module permute_engine
    import permute_engine_pkg::*;
#(
    parameter int LANE_W     = 64,
    parameter int NUM_ROUNDS = 24
) (
    input  logic           clk,
    input  logic           rst,
    permute_engine_if.slave bus
);
    localparam int S     = NUM_LANES * LANE_W;
    localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

    fsm_e             fsm_q, fsm_d;
    logic [S-1:0]     st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [S-1:0]     round_out;
    logic [CNT_W-1:0] rounds_clamped;

    permute_round #(.LANE_W(LANE_W)) u_round (
        .state_in  (st_q),
        .mode      (mode_q),
        .state_out (round_out)
    );

    assign rounds_clamped = (bus.rounds > CNT_W'(NUM_ROUNDS)) ? CNT_W'(NUM_ROUNDS) : bus.rounds;

    // Next-state, counter and datapath update
    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.start) begin
                    st_d   = bus.data_in;
                    mode_d = bus.mode;
                    cnt_d  = rounds_clamped;
                    fsm_d  = (rounds_clamped != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                st_d  = round_out;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any running job
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            st_q   <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_RHO;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign bus.busy     = (fsm_q == ST_RUN);
    assign bus.done     = (fsm_q == ST_DONE);
    assign bus.data_out = st_q;

endmodule

// File: tb/tb_permute_engine.sv
// Directed and randomized checks of permute_engine at LANE_W=64 and LANE_W=8
// against a lane-array reference model.
module tb_permute_engine;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    permute_engine_if #(.LANE_W(64), .NUM_ROUNDS(24)) if64 ();
    permute_engine_if #(.LANE_W(8),  .NUM_ROUNDS(24)) if8 ();

    permute_engine #(.LANE_W(64), .NUM_ROUNDS(24)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    permute_engine #(.LANE_W(8), .NUM_ROUNDS(24)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    // Shared stimulus; sel picks which instance receives start and is observed
    logic          sel;
    logic          start_r;
    logic [1:0]    mode_r;
    logic [4:0]    rounds_r;
    logic [1599:0] data_r;

    assign if64.start   = start_r & ~sel;
    assign if64.mode    = mode_r;
    assign if64.rounds  = rounds_r;
    assign if64.data_in = data_r;
    assign if8.start    = start_r & sel;
    assign if8.mode     = mode_r;
    assign if8.rounds   = rounds_r;
    assign if8.data_in  = data_r[199:0];

    logic          obs_busy;
    logic          obs_done;
    logic [1599:0] obs_data;

    assign obs_busy = sel ? if8.busy : if64.busy;
    assign obs_done = sel ? if8.done : if64.done;
    assign obs_data = sel ? {1400'b0, if8.data_out} : if64.data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Rotation offsets as rows y=0..4, each listing x=0..4
    localparam int RHO_T [5][5] = '{
        '{ 0,  1, 62, 28, 27},
        '{36, 44,  6, 55, 20},
        '{ 3, 10, 43, 25, 39},
        '{41, 45, 15, 21,  8},
        '{18,  2, 61, 56, 14}
    };

    task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        logic [1599:0] d;
        int fb;
        int ln;
        n_cmp++;
        d  = obs ^ exp;
        fb = 0;
        for (int i = 1599; i >= 0; i--) begin
            if (d[i] !== 1'b0) fb = i;
        end
        ln = fb / 64;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (bits %0d..%0d)",
                   tag, obs[ln*64 +: 64], exp[ln*64 +: 64], ln * 64, ln * 64 + 63);
        end
    endtask

    // Reference: unpack into 25 lanes, rotate/move lanes with plain arithmetic
    function automatic logic [1599:0] model(input logic [1599:0] din, input int m,
                                            input int n, input int w);
        longint unsigned a [25];
        longint unsigned b [25];
        longint unsigned mask;
        longint unsigned v;
        logic [1599:0]   res;
        int              r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int l = 0; l < 25; l++) begin
            a[l] = 0;
            for (int z = 0; z < w; z++) begin
                if (din[l*w+z]) a[l] = a[l] | (64'd1 << z);
            end
        end
        for (int rd = 0; rd < n; rd++) begin
            if (m != 1) begin
                for (int y = 0; y < 5; y++) begin
                    for (int x = 0; x < 5; x++) begin
                        r = RHO_T[y][x] % w;
                        v = a[x+5*y];
                        if (r != 0) a[x+5*y] = ((v << r) | (v >> (w - r))) & mask;
                    end
                end
            end
            if (m != 0) begin
                for (int y = 0; y < 5; y++) begin
                    for (int x = 0; x < 5; x++) begin
                        b[y + 5*((2*x + 3*y) % 5)] = a[x+5*y];
                    end
                end
                a = b;
            end
        end
        res = '0;
        for (int l = 0; l < 25; l++) begin
            for (int z = 0; z < w; z++) begin
                res[l*w+z] = a[l][z];
            end
        end
        return res;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Start a job, then track busy cycles, done latency, result and pulse width
    task automatic run_job(input logic [1599:0] din, input logic [1:0] m, input int r,
                           input int n_exp, input logic [1599:0] exp, input string tag);
        int k;
        int busy_cnt;
        int lat;
        @(negedge clk);
        start_r  = 1'b1;
        data_r   = din;
        mode_r   = m;
        rounds_r = r[4:0];
        @(negedge clk);
        start_r  = 1'b0;
        mode_r   = 2'($urandom);
        data_r   = rand_state();
        k        = 1;
        busy_cnt = 0;
        lat      = -1;
        while (k <= 60) begin
            if (obs_done) begin
                lat = k;
                break;
            end
            if (obs_busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check({tag, "/latency"}, lat, n_exp + 1);
        check({tag, "/busy_cycles"}, busy_cnt, n_exp);
        check({tag, "/data"}, obs_data, exp);
        @(negedge clk);
        check({tag, "/done_pulse"}, obs_done, 1'b0);
        check({tag, "/data_held"}, obs_data, exp);
    endtask

    // Reset in cycle t+10 of a long job, then confirm recovery
    task automatic abort_job(input int r, input string tag);
        int            dones;
        logic [1599:0] din;
        @(negedge clk);
        start_r  = 1'b1;
        data_r   = rand_state();
        mode_r   = 2'($urandom);
        rounds_r = r[4:0];
        @(negedge clk);
        start_r = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "/rst_busy"}, obs_busy, 1'b0);
        check({tag, "/rst_done"}, obs_done, 1'b0);
        check({tag, "/rst_data"}, obs_data, '0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (obs_done) dones++;
        end
        check({tag, "/no_done"}, dones, 0);
        din = rand_state();
        run_job(din, 2'b10, 2, 2, model(din, 2, 2, sel ? 8 : 64), {tag, "/after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] din;
        logic [1599:0] din2;
        logic [1599:0] exp;
        logic [1599:0] hot;
        int            m;
        int            r;
        int            done_other;
        logic          done25;
        logic          done27;

        sel      = 1'b0;
        rst      = 1'b1;
        start_r  = 1'b1;
        mode_r   = 2'b10;
        rounds_r = 5'd3;
        data_r   = '1;

        // reset values, with start high during reset
        repeat (3) @(negedge clk);
        check("reset64/busy", obs_busy, 1'b0);
        check("reset64/done", obs_done, 1'b0);
        check("reset64/data", obs_data, '0);
        sel = 1'b1;
        #1;
        check("reset8/busy", obs_busy, 1'b0);
        check("reset8/done", obs_done, 1'b0);
        check("reset8/data", obs_data, '0);
        sel     = 1'b0;
        start_r = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // directed single-bit cases, 64-bit lanes
        din = '0;
        din[64] = 1'b1;
        hot = '0; hot[65]  = 1'b1;
        run_job(din, 2'b00, 1, 1, hot, "rho_r1");
        hot = '0; hot[640] = 1'b1;
        run_job(din, 2'b01, 1, 1, hot, "pi_r1");
        hot = '0; hot[641] = 1'b1;
        run_job(din, 2'b10, 1, 1, hot, "rhopi_r1");
        run_job(din, 2'b11, 1, 1, hot, "reserved_r1");
        run_job(din, 2'b10, 0, 0, din, "bypass_r0");

        // full pi job and randomized jobs
        din = rand_state();
        run_job(din, 2'b01, 24, 24, model(din, 1, 24, 64), "pi_r24");
        for (int i = 0; i < 6; i++) begin
            din = rand_state();
            m   = $urandom_range(0, 3);
            r   = $urandom_range(0, 24);
            run_job(din, 2'(m), r, r, model(din, m, r, 64), $sformatf("rand64_%0d", i));
        end

        // start re-pulsed mid-job is ignored; start held through DONE restarts
        din  = rand_state();
        din2 = rand_state();
        m    = $urandom_range(0, 3);
        exp  = model(din, m, 24, 64);
        @(negedge clk);
        start_r  = 1'b1;
        data_r   = din;
        mode_r   = 2'(m);
        rounds_r = 5'd24;
        @(negedge clk);
        start_r    = 1'b0;
        done_other = 0;
        done25     = 1'b0;
        done27     = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                start_r  = 1'b1;
                mode_r   = 2'($urandom);
                data_r   = rand_state();
                rounds_r = 5'd0;
            end
            if (k == 6) start_r = 1'b0;
            if (obs_done) begin
                if (k == 25) begin
                    done25 = 1'b1;
                    check("repulse/data", obs_data, exp);
                end else if (k == 27) begin
                    done27 = 1'b1;
                    check("restart/data", obs_data, din2);
                end else begin
                    done_other++;
                end
            end
            if (k == 25) begin
                start_r  = 1'b1;
                data_r   = din2;
                rounds_r = 5'd0;
            end
            if (k == 27) start_r = 1'b0;
            @(negedge clk);
        end
        check("repulse/done_t25", done25, 1'b1);
        check("restart/done_t27", done27, 1'b1);
        check("repulse/extra_done", done_other, 0);

        // reset abort, 64-bit lanes
        abort_job(24, "abort64");

        // 8-bit lanes: clamped round count, random jobs, reset abort
        sel = 1'b1;
        din = rand_state();
        run_job(din, 2'b10, 30, 24, model(din, 2, 24, 8), "clamp8_r30");
        for (int i = 0; i < 3; i++) begin
            din = rand_state();
            m   = $urandom_range(0, 3);
            r   = $urandom_range(0, 31);
            run_job(din, 2'(m), r, (r > 24) ? 24 : r, model(din, m, (r > 24) ? 24 : r, 8),
                    $sformatf("rand8_%0d", i));
        end
        abort_job(30, "abort8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
